// File: rtl/sensor_pkg.sv
// Shared types and default parameters for the sensor conditioning block.
package sensor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRiseChk,
    StActive,
    StFallChk
  } ch_state_e;

  localparam int unsigned DefNumCh          = 4;
  localparam int unsigned DefSyncStages     = 2;
  localparam int unsigned DefDebounceCycles = 8;
  localparam int unsigned DefStuckCycles    = 1024;

endpackage

// File: rtl/sensor_channel.sv
// One sensor lane: synchroniser, debounce FSM, sticky request and stuck-high detector.
module sensor_channel
  import sensor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned STUCK_CYCLES    = DefStuckCycles
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensor_raw,
  input  logic req_ack,
  output logic detected,
  output logic detect_pulse,
  output logic req_pending,
  output logic stuck_fault
);

  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DebW-1:0]   DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  ch_state_e              state_q, state_d;
  logic [DebW-1:0]        cnt_q, cnt_d;
  logic                   deb_done;
  logic                   detected_d;
  logic [StuckW-1:0]      stuck_cnt_q, stuck_cnt_d;

  assign synced   = sync_q[SYNC_STAGES-1];
  // cnt_q holds samples already counted, so this sample completes the run
  assign deb_done = (cnt_q == DebLast);

  // cnt_q is zero whenever the FSM is not counting, so IDLE behaves as RISE_CHK
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle, StRiseChk: begin
        if (synced) begin
          state_d = deb_done ? StActive : StRiseChk;
          cnt_d   = deb_done ? '0 : cnt_q + DebW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      StActive, StFallChk: begin
        if (!synced) begin
          state_d = deb_done ? StIdle : StFallChk;
          cnt_d   = deb_done ? '0 : cnt_q + DebW'(1);
        end else begin
          state_d = StActive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign detected_d = (state_d == StActive) || (state_d == StFallChk);

  always_comb begin
    stuck_cnt_d = '0;
    if (detected) begin
      stuck_cnt_d = (stuck_cnt_q == StuckMax) ? stuck_cnt_q : stuck_cnt_q + StuckW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      detected     <= 1'b0;
      detect_pulse <= 1'b0;
      req_pending  <= 1'b0;
      stuck_cnt_q  <= '0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      detected     <= detected_d;
      detect_pulse <= detected_d & ~detected;
      // A new pulse overrides a simultaneous acknowledge
      req_pending  <= detect_pulse | (req_pending & ~req_ack);
      stuck_cnt_q  <= stuck_cnt_d;
    end
  end

  assign stuck_fault = (stuck_cnt_q == StuckMax);

endmodule

// File: rtl/sensor_conditioner.sv
// Replicates one independent sensor_channel per lane.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned NUM_CH          = DefNumCh,
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned STUCK_CYCLES    = DefStuckCycles
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] sensor_raw,
  input  logic [NUM_CH-1:0] req_ack,
  output logic [NUM_CH-1:0] detected,
  output logic [NUM_CH-1:0] detect_pulse,
  output logic [NUM_CH-1:0] req_pending,
  output logic [NUM_CH-1:0] stuck_fault
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sensor_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .sensor_raw  (sensor_raw[g]),
      .req_ack     (req_ack[g]),
      .detected    (detected[g]),
      .detect_pulse(detect_pulse[g]),
      .req_pending (req_pending[g]),
      .stuck_fault (stuck_fault[g])
    );
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed and randomized checks of sensor_conditioner against a behavioural lane model.
module tb_sensor_conditioner;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int STUCK  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NUM_CH-1:0] sensor_raw = '0;
  logic [NUM_CH-1:0] req_ack = '0;
  logic [NUM_CH-1:0] detected, detect_pulse, req_pending, stuck_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: raw samples in flight, plus per-lane run lengths
  logic [NUM_CH-1:0] raw_hist[$];
  logic [NUM_CH-1:0] det_m, pulse_m, req_m, stuck_m;
  int                opp_run[NUM_CH];
  int                high_run[NUM_CH];

  sensor_conditioner #(
    .NUM_CH         (NUM_CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .STUCK_CYCLES   (STUCK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor_raw  (sensor_raw),
    .req_ack     (req_ack),
    .detected    (detected),
    .detect_pulse(detect_pulse),
    .req_pending (req_pending),
    .stuck_fault (stuck_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    repeat (SYNC) raw_hist.push_back('0);
    det_m = '0; pulse_m = '0; req_m = '0; stuck_m = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      opp_run[c]  = 0;
      high_run[c] = 0;
    end
  endtask

  // Level flips once DEB consecutive synchronised samples disagree with it
  task automatic model_edge();
    logic [NUM_CH-1:0] s, det_next;
    s = raw_hist.pop_front();
    raw_hist.push_back(sensor_raw);
    det_next = det_m;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s[c] != det_m[c]) begin
        opp_run[c]++;
        if (opp_run[c] == DEB) begin
          det_next[c] = ~det_m[c];
          opp_run[c]  = 0;
        end
      end else begin
        opp_run[c] = 0;
      end
      high_run[c] = det_m[c] ? ((high_run[c] < STUCK) ? high_run[c] + 1 : STUCK) : 0;
      stuck_m[c]  = (high_run[c] >= STUCK);
    end
    req_m   = pulse_m | (req_m & ~req_ack);
    pulse_m = det_next & ~det_m;
    det_m   = det_next;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("detected", 32'(detected), 32'(det_m));
    check_eq("detect_pulse", 32'(detect_pulse), 32'(pulse_m));
    check_eq("req_pending", 32'(req_pending), 32'(req_m));
    check_eq("stuck_fault", 32'(stuck_fault), 32'(stuck_m));
  endtask

  // Asserted just after an edge, held across one edge, released just after it
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_detected", 32'(detected), 32'd0);
    check_eq("rst_pulse", 32'(detect_pulse), 32'd0);
    check_eq("rst_req", 32'(req_pending), 32'd0);
    check_eq("rst_stuck", 32'(stuck_fault), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [NUM_CH-1:0] ch1_seen;
    int span;
    #2;
    do_reset();

    // ch0 clean rising edge: detected after SYNC+DEB edges, request one edge later
    sensor_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq("ch0_det", 32'(detected[0]), 32'(k >= 6));
      check_eq("ch0_pulse", 32'(detect_pulse[0]), 32'(k == 6));
      check_eq("ch0_req", 32'(req_pending[0]), 32'(k >= 7));
    end

    // ch2: ack coinciding with a fresh pulse must not clear the request
    sensor_raw[2] = 1'b1;
    for (int i = 0; i < 20 && !req_m[2]; i++) step();
    check_eq("ch2_req_set", 32'(req_pending[2]), 32'd1);
    sensor_raw[2] = 1'b0;
    for (int i = 0; i < 20 && det_m[2]; i++) step();
    check_eq("ch2_det_fall", 32'(detected[2]), 32'd0);
    sensor_raw[2] = 1'b1;
    for (int i = 0; i < 20 && !pulse_m[2]; i++) step();
    check_eq("ch2_pulse_again", 32'(detect_pulse[2]), 32'd1);
    req_ack[2] = 1'b1;
    step();
    check_eq("ch2_set_wins", 32'(req_pending[2]), 32'd1);
    req_ack[2] = 1'b0;
    step();
    check_eq("ch2_req_hold", 32'(req_pending[2]), 32'd1);
    req_ack[2] = 1'b1;
    step();
    check_eq("ch2_ack_clear", 32'(req_pending[2]), 32'd0);
    step();
    check_eq("ch2_ack_ignored", 32'(req_pending[2]), 32'd0);
    req_ack[2] = 1'b0;

    // ch1 glitch shorter than the debounce window is invisible
    ch1_seen = '0;
    sensor_raw[1] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      sensor_raw[1] = (k <= 3);
      step();
      ch1_seen = ch1_seen | {1'b0, detected[1], detect_pulse[1], req_pending[1]};
    end
    check_eq("ch1_glitch", 32'(ch1_seen), 32'd0);

    // ch3 held high 40 cycles: stuck 16 edges after detect, clears the edge after fall
    for (int k = 1; k <= 50; k++) begin
      sensor_raw[3] = (k <= 40);
      step();
      check_eq("ch3_det", 32'(detected[3]), 32'(k >= 6 && k < 46));
      check_eq("ch3_stuck", 32'(stuck_fault[3]), 32'(k >= 22 && k < 47));
    end

    // Reset mid-debounce on ch0 and mid-request on ch2
    sensor_raw = '0;
    do_reset();
    sensor_raw[2] = 1'b1;
    for (int i = 0; i < 20 && !req_m[2]; i++) step();
    check_eq("ch2_req_pre_rst", 32'(req_pending[2]), 32'd1);
    sensor_raw[0] = 1'b1;
    repeat (4) step();
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step();
      check_eq("ch0_det_post_rst", 32'(detected[0]), 32'(k >= 6));
    end

    // Randomized traffic with varying toggle density and occasional resets
    span = 6;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 400 == 0) begin
        case ($urandom_range(0, 2))
          0: span = 3;
          1: span = 8;
          default: span = 30;
        endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, span - 1) == 0) sensor_raw[c] = ~sensor_raw[c];
        req_ack[c] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
